// File: rtl/i2c_sched_pkg.sv
// i2c_sched_pkg: shared state encoding, engine command codes and watchdog limit
package i2c_sched_pkg;
   typedef enum logic [3:0] {
      ST_IDLE, ST_START, ST_ADDR, ST_WAIT_TX, ST_WDATA, ST_RD, ST_PUSH, ST_STOP, ST_DONE
   } state_t;
   localparam logic [1:0] ENG_START = 2'b00;
   localparam logic [1:0] ENG_WRITE = 2'b01;
   localparam logic [1:0] ENG_READ  = 2'b10;
   localparam logic [1:0] ENG_STOP  = 2'b11;
   localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;
   function automatic logic issues_cmd(input state_t s);
      return s == ST_START || s == ST_ADDR || s == ST_WDATA || s == ST_RD || s == ST_STOP;
   endfunction
endpackage

// File: rtl/i2c_sched_wdog.sv
// i2c_sched_wdog: saturating wait counter; flags expiry once it sits at TIMEOUT_LIMIT while still waiting
module i2c_sched_wdog
   import i2c_sched_pkg::*;
(
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_wait,
   output logic o_expired
);
   logic [7:0] r_cnt;
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) r_cnt <= '0;
      else if (i_wait && r_cnt != TIMEOUT_LIMIT) r_cnt <= r_cnt + 8'd1;
   end
   assign o_expired = i_wait && (r_cnt == TIMEOUT_LIMIT);
endmodule

// File: rtl/i2c_xfer_sched.sv
// i2c_xfer_sched: sequences one I2C transfer into byte-level engine commands between TX/RX FIFOs.
// Define I2C_SCHED_TIMEOUT_EN to add the engine-response watchdog (err_timeout / eng_abort).
module i2c_xfer_sched
   import i2c_sched_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic       i_cmd_rw,
   input  logic [6:0] i_cmd_addr,
   input  logic [4:0] i_cmd_len,
   output logic       o_tx_rd,
   input  logic [7:0] i_tx_data,
   input  logic       i_tx_empty,
   output logic       o_rx_wr,
   output logic [7:0] o_rx_data,
   input  logic       i_rx_full,
   output logic       o_eng_cmd_valid,
   output logic [1:0] o_eng_cmd,
   output logic [7:0] o_eng_wdata,
   output logic       o_eng_ack_out,
   input  logic       i_eng_done,
   input  logic       i_eng_nack,
   input  logic [7:0] i_eng_rdata,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err_nack,
   output logic       o_err_timeout,
   output logic       o_eng_abort
);
   state_t     r_state, w_next;
   logic       r_new, r_rw;
   logic [6:0] r_addr;
   logic [4:0] r_rem;
   logic [7:0] r_txb, r_rxb;
   logic       w_done, w_last, w_tmo;
   // r_new marks the issue cycle of a state; a done seen then belongs to nothing
   assign w_done = i_eng_done && !r_new;
   assign w_last = r_rem == 5'd1;
`ifdef I2C_SCHED_TIMEOUT_EN
   logic w_wait;
   assign w_wait = issues_cmd(r_state) && !r_new && !i_eng_done;
   i2c_sched_wdog u_wdog (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clr     (o_eng_cmd_valid),
      .i_wait    (w_wait),
      .o_expired (w_tmo)
   );
`else
   assign w_tmo = 1'b0;
`endif
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_new   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_new   <= w_next != r_state;
      end
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (i_cmd_valid) w_next = ST_START;
         ST_START:   if (w_done) w_next = ST_ADDR;
         ST_ADDR:    if (w_done) w_next = (i_eng_nack || r_rem == 5'd0) ? ST_STOP : r_rw ? ST_RD : ST_WAIT_TX;
         ST_WAIT_TX: if (!i_tx_empty) w_next = ST_WDATA;
         ST_WDATA:   if (w_done) w_next = (i_eng_nack || w_last) ? ST_STOP : ST_WAIT_TX;
         ST_RD:      if (w_done) w_next = ST_PUSH;
         ST_PUSH:    if (!i_rx_full) w_next = w_last ? ST_STOP : ST_RD;
         ST_STOP:    if (w_done) w_next = ST_DONE;
         default:    w_next = ST_IDLE;
      endcase
      if (w_tmo) w_next = ST_IDLE;
   end
   always_comb begin
      o_cmd_ready     = r_state == ST_IDLE;
      o_busy          = r_state != ST_IDLE;
      o_eng_cmd_valid = r_new && issues_cmd(r_state);
      o_eng_cmd       = (r_state == ST_ADDR || r_state == ST_WDATA) ? ENG_WRITE :
                        r_state == ST_RD ? ENG_READ : r_state == ST_STOP ? ENG_STOP : ENG_START;
      o_eng_wdata     = r_state == ST_ADDR ? {r_addr, r_rw} : r_state == ST_WDATA ? r_txb : 8'h00;
      o_eng_ack_out   = r_state == ST_RD && !w_last;
      o_tx_rd         = r_state == ST_WAIT_TX && !i_tx_empty;
      o_rx_wr         = r_state == ST_PUSH && !i_rx_full;
      o_rx_data       = r_rxb;
      o_done          = r_state == ST_DONE;
      o_err_nack      = w_done && i_eng_nack && (r_state == ST_ADDR || r_state == ST_WDATA);
      o_err_timeout   = w_tmo;
      o_eng_abort     = w_tmo;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rw   <= 1'b0;
         r_addr <= '0;
         r_rem  <= '0;
         r_txb  <= '0;
         r_rxb  <= '0;
      end else begin
         if (i_cmd_valid && o_cmd_ready) {r_rw, r_addr, r_rem} <= {i_cmd_rw, i_cmd_addr, i_cmd_len};
         else if ((r_state == ST_WDATA && w_done && !i_eng_nack) || o_rx_wr) r_rem <= r_rem - 5'd1;
         if (o_tx_rd) r_txb <= i_tx_data;
         if (r_state == ST_RD && w_done) r_rxb <= i_eng_rdata;
      end
   end
endmodule

// File: doc/i2c_xfer_sched.md
I2C_XFER_SCHED -- requirements
Module: i2c_xfer_sched

Interface
REQ-001 SHALL have: clk  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: cmd_valid in 1 / cmd_ready out 1  command handshake.
REQ-004 SHALL have: cmd_rw in 1, where 0 = write and 1 = read; cmd_addr in 7 (slave address); cmd_len in 5 (byte count, 0..31).
REQ-005 SHALL have: tx_rd out 1 (TX FIFO pop); tx_data in 8 (FIFO head, combinational); tx_empty in 1.
REQ-006 SHALL have: rx_wr out 1 (RX FIFO push); rx_data out 8; rx_full in 1.
REQ-007 SHALL have: eng_cmd_valid out 1 (one-cycle issue pulse); eng_cmd out 2; eng_wdata out 8; eng_ack_out out 1 (1 = master ACK on read byte).
REQ-008 SHALL have: eng_done in 1 (one-cycle completion pulse); eng_nack in 1 (valid with eng_done); eng_rdata in 8 (valid with eng_done).
REQ-009 SHALL have: busy out 1; done out 1 (pulse); err_nack out 1 (pulse); err_timeout out 1 (pulse); eng_abort out 1 (pulse).

Function
REQ-010 SHALL implement states IDLE, START, ADDR, WAIT_TX, WDATA, RD, PUSH, STOP, DONE; busy=1 in all states except IDLE.
REQ-011 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, latch rw, addr and len into a 5-bit remaining counter, then enter START.
REQ-012 SHALL, in START/ADDR/WDATA/RD/STOP, pulse eng_cmd_valid in the first cycle of the state only, holding eng_cmd/eng_wdata/eng_ack_out stable until eng_done; eng_done in the issue cycle is ignored.
REQ-013 START: wait for eng_done, then go to ADDR. ADDR: eng_wdata={addr,rw}; on done with eng_nack, pulse err_nack and go to STOP; on done with len==0, go to STOP; otherwise go to WAIT_TX (rw=0) or RD (rw=1).
REQ-014 WAIT_TX: while tx_empty, hold; when !tx_empty, assert tx_rd for one cycle, latch tx_data in the same cycle, and go to WDATA.
REQ-015 WDATA: on done with eng_nack, pulse err_nack and go to STOP (remaining bytes are not popped); otherwise decrement remaining and go to STOP if it reaches 0, else WAIT_TX.
REQ-016 RD: eng_ack_out=0 when remaining==1, else 1; on done, latch eng_rdata and go to PUSH.
REQ-017 PUSH: while rx_full, hold with rx_wr=0; when !rx_full, assert rx_wr for one cycle with rx_data=latched byte, decrement remaining, and go to STOP if it reaches 0, else RD.
REQ-018 STOP: on eng_done, go to DONE; DONE pulses done for one cycle, then goes to IDLE.
REQ-019 tx_rd SHALL never assert while tx_empty=1; rx_wr SHALL never assert while rx_full=1.
REQ-020 cmd_valid outside IDLE SHALL be ignored (no queuing).

Reset
REQ-021 reset=1 SHALL force IDLE at the next edge from any state, with no STOP issued.
REQ-022 Reset values: cmd_ready=1, busy=0; all other outputs 0; remaining=0; all latches 0.

Configuration
REQ-023 With I2C_SCHED_TIMEOUT_EN defined: an 8-bit watchdog clears on each eng_cmd_valid and counts each cycle spent waiting for eng_done.
REQ-024 With I2C_SCHED_TIMEOUT_EN defined: when the watchdog reaches 255, pulse err_timeout and eng_abort together and go directly to IDLE (no STOP).
REQ-025 Without I2C_SCHED_TIMEOUT_EN: no watchdog is present; err_timeout and eng_abort are tied to 0; the block waits for eng_done indefinitely. Ports are identical in both builds.

Structure
REQ-026 Package i2c_sched_pkg SHALL hold the state enum, eng_cmd encodings (START=2'b00, WRITE=2'b01, READ=2'b10, STOP=2'b11) and TIMEOUT_LIMIT=255.
REQ-027 The watchdog SHALL be sub-module i2c_sched_wdog, instantiated only under I2C_SCHED_TIMEOUT_EN.

Verification
REQ-028 Write, addr=0x50, len=2, TX holds 0xA1,0xB2, engine always ACKs -> eng sequence START, WRITE 0xA0, WRITE 0xA1, WRITE 0xB2, STOP; 2 tx_rd pulses; then done.
REQ-029 Read, addr=0x3C, len=3, engine returns 0x11,0x22,0x33 -> rx_wr pushes 0x11,0x22,0x33; eng_ack_out=1,1,0; then STOP and done.
REQ-030 Write, len=3, eng_nack on the 2nd data byte -> err_nack pulse, then STOP; exactly 2 tx_rd pulses; then done.
REQ-031 Read, len=2, rx_full held high for 10 cycles after the 1st byte -> rx_wr delayed until rx_full drops; no data lost.
REQ-032 Write, len=1, tx_empty high for 20 cycles, then reset asserted mid-WDATA -> no tx_rd while empty; after reset, IDLE with all outputs at reset values.
REQ-033 With I2C_SCHED_TIMEOUT_EN, engine never returns eng_done after START -> err_timeout and eng_abort pulse 256 cycles after issue; block returns to IDLE.
